// File: rtl/ram_antwort_if.sv
// Request/acknowledge bundle between the cache's RAM port (master) and the
// memory responder (slave).
interface ram_antwort_if;
    logic        Schreiben;
    logic        Lesen;
    logic [31:0] Adresse;
    logic [31:0] SchreibDaten;
    logic [31:0] LesDaten;
    logic        DatenGelesen;
    logic        DatenGeladen;
    logic        Belegt;

    modport master (
        output Schreiben, Lesen, Adresse, SchreibDaten,
        input  LesDaten, DatenGelesen, DatenGeladen, Belegt
    );

    modport slave (
        input  Schreiben, Lesen, Adresse, SchreibDaten,
        output LesDaten, DatenGelesen, DatenGeladen, Belegt
    );
endinterface

// File: rtl/ram_antwort.sv
// Word-addressed block-RAM backing store answering one cache request at a
// time after a fixed latency, followed by a one-cycle recovery slot.
module ram_antwort #(
    parameter int ADRESSBITS = 12,
    parameter int LATENZ     = 2
) (
    input  logic          Takt,
    input  logic          Reset,
    ram_antwort_if.slave  ram
);
    typedef enum logic [1:0] {
        BEREIT     = 2'd0,
        WARTEN     = 2'd1,
        QUITTIEREN = 2'd2,
        ERHOLEN    = 2'd3
    } zustand_t;

    zustand_t              r_zustand;
    zustand_t              w_zustand_next;
    logic [3:0]            r_zaehler;
    logic [ADRESSBITS-1:0] r_index;
    logic [31:0]           r_daten;
    logic                  r_schreiben;
    logic [31:0]           r_les_daten;
    logic [31:0]           r_mem [2**ADRESSBITS];

    logic w_annahme;
    logic w_fertig;

    assign w_annahme = (r_zustand == BEREIT) && (ram.Schreiben || ram.Lesen);
    assign w_fertig  = (r_zustand == WARTEN) && (r_zaehler == 4'd0);

    always_ff @(posedge Takt) begin
        if (Reset) begin
            r_zustand <= BEREIT;
        end else begin
            r_zustand <= w_zustand_next;
        end
    end

    always_comb begin
        w_zustand_next = r_zustand;
        case (r_zustand)
            BEREIT:     if (w_annahme) w_zustand_next = WARTEN;
            WARTEN:     if (w_fertig)  w_zustand_next = QUITTIEREN;
            QUITTIEREN: w_zustand_next = ERHOLEN;
            ERHOLEN:    w_zustand_next = BEREIT;
            default:    w_zustand_next = BEREIT;
        endcase
    end

    // Request capture: the requester may drop or change its inputs once latched.
    always_ff @(posedge Takt) begin
        if (Reset) begin
            r_zaehler   <= 4'd0;
            r_index     <= '0;
            r_daten     <= 32'd0;
            r_schreiben <= 1'b0;
        end else if (w_annahme) begin
            r_zaehler   <= 4'(LATENZ - 1);
            r_index     <= ram.Adresse[ADRESSBITS+1:2];
            r_daten     <= ram.SchreibDaten;
            r_schreiben <= ram.Schreiben;
        end else if (r_zustand == WARTEN && r_zaehler != 4'd0) begin
            r_zaehler <= r_zaehler - 4'd1;
        end
    end

    // Memory contents survive reset; a reset on the final WARTEN edge blocks the commit.
    always_ff @(posedge Takt) begin
        if (!Reset && w_fertig && r_schreiben) begin
            r_mem[r_index] <= r_daten;
        end
    end

    always_ff @(posedge Takt) begin
        if (Reset) begin
            r_les_daten <= 32'd0;
        end else if (w_fertig && !r_schreiben) begin
            r_les_daten <= r_mem[r_index];
        end
    end

    always_comb begin
        ram.LesDaten     = r_les_daten;
        ram.DatenGelesen = (r_zustand == QUITTIEREN) &&  r_schreiben;
        ram.DatenGeladen = (r_zustand == QUITTIEREN) && !r_schreiben;
        ram.Belegt       = (r_zustand != BEREIT);
    end
endmodule

// File: tb/tb_ram_antwort.sv
// Randomized bench for ram_antwort against a word-indexed memory model and
// the request-to-acknowledge timing rules.
module tb_ram_antwort;
    localparam int AB = 12;
    localparam int L  = 2;

    logic Takt = 1'b0;
    logic Reset;
    always #5 Takt = ~Takt;

    ram_antwort_if ram ();

    ram_antwort #(.ADRESSBITS(AB), .LATENZ(L)) dut (
        .Takt  (Takt),
        .Reset (Reset),
        .ram   (ram)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [int];
    logic [31:0] exp_les;
    bit          les_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AB) - 32'd1));
    endfunction

    function automatic logic [31:0] acks();
        return {30'd0, ram.DatenGelesen, ram.DatenGeladen};
    endfunction

    task automatic tick();
        @(posedge Takt);
        #1;
    endtask

    // One complete request, from first sampling edge to the return to BEREIT.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        int i;
        i = idx(addr);
        ram.Schreiben    = wr;
        ram.Lesen        = rd;
        ram.Adresse      = addr;
        ram.SchreibDaten = data;
        for (int s = 1; s <= L + 3; s++) begin
            tick();
            if (s == 1) check("belegt_start", 32'(ram.Belegt), 32'd1);
            if (s <= L) check("ack_early", acks(), 32'd0);
            if (s == L + 1) begin
                check("ack_pulse", acks(), wr ? 32'd2 : 32'd1);
                if (wr) begin
                    model[i] = data;
                end else if (model.exists(i)) begin
                    check("les_daten", ram.LesDaten, model[i]);
                    exp_les   = model[i];
                    les_known = 1'b1;
                end else begin
                    les_known = 1'b0;
                end
                ram.Schreiben = 1'b0;
                ram.Lesen     = 1'b0;
            end
            if (s == L + 2) begin
                check("ack_once", acks(), 32'd0);
                check("belegt_erholen", 32'(ram.Belegt), 32'd1);
            end
            if (s == L + 3) begin
                check("belegt_end", 32'(ram.Belegt), 32'd0);
                if (les_known) check("les_hold", ram.LesDaten, exp_les);
            end
        end
        $display("txn %s addr=0x%08h data=0x%08h les=0x%08h",
                 wr ? "WR" : "RD", addr, data, ram.LesDaten);
    endtask

    // Read whose requester keeps Lesen high for 'extra' cycles after the acknowledge.
    task automatic hold_read(input logic [31:0] addr, input int extra);
        logic [31:0] v;
        v = model[idx(addr)];
        ram.Lesen   = 1'b1;
        ram.Adresse = addr;
        for (int s = 1; s <= L + 1; s++) tick();
        check("hold_ack1", acks(), 32'd1);
        check("hold_data1", ram.LesDaten, v);
        for (int e = 1; e <= extra; e++) begin
            tick();
            check("hold_noretrig", acks(), 32'd0);
        end
        ram.Lesen = 1'b0;
        if (extra >= 3) begin
            for (int s = L + 5; s <= 2 * L + 6; s++) begin
                tick();
                if (s == 2 * L + 4) begin
                    check("hold_ack2", acks(), 32'd1);
                    check("hold_data2", ram.LesDaten, v);
                end else begin
                    check("hold_ack2_only", acks(), 32'd0);
                end
            end
        end else begin
            for (int s = 0; s < L + 2; s++) begin
                tick();
                check("hold_idle_ack", acks(), 32'd0);
            end
        end
        check("hold_belegt_end", 32'(ram.Belegt), 32'd0);
        exp_les = v;
        les_known = 1'b1;
        $display("hold_read addr=0x%08h extra=%0d les=0x%08h", addr, extra, ram.LesDaten);
    endtask

    initial begin
        logic [31:0] pool [6];
        logic [31:0] mask;
        logic [31:0] addr;
        int          op;

        les_known        = 1'b0;
        exp_les          = 32'd0;
        Reset            = 1'b1;
        ram.Schreiben    = 1'b0;
        ram.Lesen        = 1'b0;
        ram.Adresse      = 32'd0;
        ram.SchreibDaten = 32'd0;
        repeat (3) tick();
        check("rst_les", ram.LesDaten, 32'd0);
        check("rst_acks", acks(), 32'd0);
        check("rst_belegt", 32'(ram.Belegt), 32'd0);
        Reset = 1'b0;
        tick();

        txn(1'b0, 1'b1, 32'h10, 32'h0);
        txn(1'b1, 1'b0, 32'h20, 32'hDEADBEEF);
        txn(1'b0, 1'b1, 32'h20, 32'h0);
        txn(1'b1, 1'b1, 32'h4, 32'h12345678);
        txn(1'b0, 1'b1, 32'h4, 32'h0);
        hold_read(32'h20, 2);
        hold_read(32'h4, 3);

        // Reset while the write is still waiting: no commit, no acknowledge.
        txn(1'b1, 1'b0, 32'h30, 32'h11110030);
        ram.Schreiben    = 1'b1;
        ram.Adresse      = 32'h30;
        ram.SchreibDaten = 32'hCAFEF00D;
        tick();
        Reset = 1'b1;
        tick();
        check("rstw_acks", acks(), 32'd0);
        check("rstw_belegt", 32'(ram.Belegt), 32'd0);
        check("rstw_les", ram.LesDaten, 32'd0);
        Reset         = 1'b0;
        ram.Schreiben = 1'b0;
        exp_les       = 32'd0;
        les_known     = 1'b1;
        for (int k = 0; k < L + 3; k++) begin
            tick();
            check("rstw_quiet", acks(), 32'd0);
        end
        txn(1'b0, 1'b1, 32'h30, 32'h0);

        txn(1'b1, 1'b0, 32'h4004, 32'hA5A5A5A5);
        txn(1'b0, 1'b1, 32'h0004, 32'h0);
        txn(1'b0, 1'b1, 32'h0006, 32'h0);

        mask = (((32'd1 << AB) - 32'd1) << 2) | 32'd3;
        for (int p = 0; p < 6; p++) begin
            pool[p] = 32'($urandom_range(0, (1 << AB) - 1));
            txn(1'b1, 1'b0, pool[p] << 2, $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            addr = ($urandom & ~mask) | (pool[$urandom_range(0, 5)] << 2) | 32'($urandom_range(0, 3));
            op   = $urandom_range(0, 3);
            case (op)
                0, 1:    txn(1'b1, 1'b0, addr, $urandom);
                2:       txn(1'b0, 1'b1, addr, $urandom);
                default: txn(1'b1, 1'b1, addr, $urandom);
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
